// File: rtl/multi_test_clk.sv
// multi_test_clk: CHANNELS independent synthetic test clocks for clock-recovery
// benches and loopback self-test. Each channel has its own high/low rates,
// starting polarity, phase offset and programmable rate drift. All timing is
// counted in clk_en-qualified system cycles.
//
// Ports:
//   clk                  system clock
//   async_rst            asynchronous active-high reset
//   clk_en               global cycle qualifier; all state holds when low
//   init_i               capture per-channel config into shadows, all channels to IDLE
//   generation_en_i      per-channel run/pause
//   starting_polarity_i  clk_o level after init
//   high_rate_i          per-channel cycles high   ([c*RATE_WIDTH +: RATE_WIDTH])
//   low_rate_i           per-channel cycles low
//   phase_offset_i       extra cycles the initial level is held
//   drift_en_i           per-channel drift enable (live, not shadowed)
//   drift_polarity_i     0 = rates grow, 1 = rates shrink
//   drift_interval_i     rising edges between drift steps; 0 disables drift
//   clk_o                generated clocks
//   rise_o / fall_o      1-cycle pulses coincident with clk_o edges
//   drift_applied_o      1-cycle pulse when the shadow rates step
//   active_o             channel is in OFFSET, HIGH or LOW
module multi_test_clk #(
  parameter int CHANNELS    = 2,
  parameter int RATE_WIDTH  = 16,
  parameter int DRIFT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           async_rst,
  input  logic                           clk_en,
  input  logic                           init_i,
  input  logic [CHANNELS-1:0]            generation_en_i,
  input  logic [CHANNELS-1:0]            starting_polarity_i,
  input  logic [CHANNELS*RATE_WIDTH-1:0] high_rate_i,
  input  logic [CHANNELS*RATE_WIDTH-1:0] low_rate_i,
  input  logic [CHANNELS*RATE_WIDTH-1:0] phase_offset_i,
  input  logic [CHANNELS-1:0]            drift_en_i,
  input  logic [CHANNELS-1:0]            drift_polarity_i,
  input  logic [CHANNELS*DRIFT_WIDTH-1:0] drift_interval_i,
  output logic [CHANNELS-1:0]            clk_o,
  output logic [CHANNELS-1:0]            rise_o,
  output logic [CHANNELS-1:0]            fall_o,
  output logic [CHANNELS-1:0]            drift_applied_o,
  output logic [CHANNELS-1:0]            active_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFSET = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } state_t;

  localparam logic [RATE_WIDTH-1:0]  RATE_ZERO  = {RATE_WIDTH{1'b0}};
  localparam logic [RATE_WIDTH-1:0]  RATE_ONE   = {{(RATE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RATE_WIDTH-1:0]  RATE_MAX   = {RATE_WIDTH{1'b1}};
  localparam logic [DRIFT_WIDTH-1:0] DRIFT_ZERO = {DRIFT_WIDTH{1'b0}};
  localparam logic [DRIFT_WIDTH:0]   DRIFT_INC  = {{DRIFT_WIDTH{1'b0}}, 1'b1};

  // A programmed rate of 0 behaves as 1.
  function automatic logic [RATE_WIDTH-1:0] eff_rate(input logic [RATE_WIDTH-1:0] r);
    if (r == RATE_ZERO) begin
      return RATE_ONE;
    end else begin
      return r;
    end
  endfunction

  // One drift step, saturating inside [1, 2^RATE_WIDTH-1].
  function automatic logic [RATE_WIDTH-1:0] drift_step(input logic [RATE_WIDTH-1:0] r,
                                                       input logic shrink);
    logic [RATE_WIDTH-1:0] e;
    e = eff_rate(r);
    if (shrink) begin
      if (e == RATE_ONE) begin
        return RATE_ONE;
      end else begin
        return e - RATE_ONE;
      end
    end else begin
      if (e == RATE_MAX) begin
        return RATE_MAX;
      end else begin
        return e + RATE_ONE;
      end
    end
  endfunction

  genvar c;
  for (c = 0; c < CHANNELS; c++) begin : g_ch
    state_t                 state_r, state_s;
    logic [RATE_WIDTH-1:0]  count_r, count_s;
    logic [RATE_WIDTH-1:0]  hi_r, hi_s, lo_r, lo_s, off_r, off_s;
    logic [DRIFT_WIDTH-1:0] dint_r, dint_s, ecnt_r, ecnt_s;
    logic [DRIFT_WIDTH:0]   ecnt_inc_s;
    logic                   dpol_r, dpol_s;
    logic                   cfg_r, cfg_s;  // set by init; reset leaves the channel unconfigured
    logic                   clk_r, clk_s, rise_r, rise_s, fall_r, fall_s;
    logic                   drift_r, drift_s, active_r, active_s;

    assign ecnt_inc_s = {1'b0, ecnt_r} + DRIFT_INC;

    // Next-state, shadow and pulse computation for this channel.
    always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      hi_s     = hi_r;
      lo_s     = lo_r;
      off_s    = off_r;
      dint_s   = dint_r;
      dpol_s   = dpol_r;
      ecnt_s   = ecnt_r;
      cfg_s    = cfg_r;
      clk_s    = clk_r;
      rise_s   = 1'b0;
      fall_s   = 1'b0;
      drift_s  = 1'b0;
      if (!clk_en) begin
        state_s = state_r;
      end else if (init_i) begin
        state_s = ST_IDLE;
        count_s = RATE_ZERO;
        hi_s    = high_rate_i[c*RATE_WIDTH +: RATE_WIDTH];
        lo_s    = low_rate_i[c*RATE_WIDTH +: RATE_WIDTH];
        off_s   = phase_offset_i[c*RATE_WIDTH +: RATE_WIDTH];
        dint_s  = drift_interval_i[c*DRIFT_WIDTH +: DRIFT_WIDTH];
        dpol_s  = drift_polarity_i[c];
        ecnt_s  = DRIFT_ZERO;
        cfg_s   = 1'b1;
        clk_s   = starting_polarity_i[c];
      end else if (!generation_en_i[c]) begin
        // Paused (or idle and not started): everything holds.
        state_s = state_r;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (!cfg_r) begin
              state_s = ST_IDLE;
            end else if (off_r != RATE_ZERO) begin
              state_s = ST_OFFSET;
              count_s = off_r - RATE_ONE;
            end else if (clk_r) begin
              state_s = ST_HIGH;
              count_s = eff_rate(hi_r) - RATE_ONE;
            end else begin
              state_s = ST_LOW;
              count_s = eff_rate(lo_r) - RATE_ONE;
            end
          end
          ST_OFFSET: begin
            if (count_r != RATE_ZERO) begin
              count_s = count_r - RATE_ONE;
            end else if (clk_r) begin
              state_s = ST_HIGH;
              count_s = eff_rate(hi_r) - RATE_ONE;
            end else begin
              state_s = ST_LOW;
              count_s = eff_rate(lo_r) - RATE_ONE;
            end
          end
          ST_HIGH: begin
            if (count_r != RATE_ZERO) begin
              count_s = count_r - RATE_ONE;
            end else begin
              state_s = ST_LOW;
              count_s = eff_rate(lo_r) - RATE_ONE;
              clk_s   = 1'b0;
              fall_s  = 1'b1;
            end
          end
          ST_LOW: begin
            if (count_r != RATE_ZERO) begin
              count_s = count_r - RATE_ONE;
            end else begin
              // The HIGH load reads hi_r, i.e. the shadow before any drift step below.
              state_s = ST_HIGH;
              count_s = eff_rate(hi_r) - RATE_ONE;
              clk_s   = 1'b1;
              rise_s  = 1'b1;
              if (drift_en_i[c] && (dint_r != DRIFT_ZERO)) begin
                if (ecnt_inc_s >= {1'b0, dint_r}) begin
                  ecnt_s  = DRIFT_ZERO;
                  hi_s    = drift_step(hi_r, dpol_r);
                  lo_s    = drift_step(lo_r, dpol_r);
                  drift_s = 1'b1;
                end else begin
                  ecnt_s = ecnt_inc_s[DRIFT_WIDTH-1:0];
                end
              end else begin
                ecnt_s = ecnt_r;
              end
            end
          end
          default: begin
            state_s = ST_IDLE;
          end
        endcase
      end
      active_s = (state_s != ST_IDLE);
    end

    // Channel state, shadows and registered outputs.
    always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
        state_r  <= ST_IDLE;
        count_r  <= RATE_ZERO;
        hi_r     <= RATE_ZERO;
        lo_r     <= RATE_ZERO;
        off_r    <= RATE_ZERO;
        dint_r   <= DRIFT_ZERO;
        dpol_r   <= 1'b0;
        ecnt_r   <= DRIFT_ZERO;
        cfg_r    <= 1'b0;
        clk_r    <= 1'b0;
        rise_r   <= 1'b0;
        fall_r   <= 1'b0;
        drift_r  <= 1'b0;
        active_r <= 1'b0;
      end else begin
        state_r  <= state_s;
        count_r  <= count_s;
        hi_r     <= hi_s;
        lo_r     <= lo_s;
        off_r    <= off_s;
        dint_r   <= dint_s;
        dpol_r   <= dpol_s;
        ecnt_r   <= ecnt_s;
        cfg_r    <= cfg_s;
        clk_r    <= clk_s;
        rise_r   <= rise_s;
        fall_r   <= fall_s;
        drift_r  <= drift_s;
        active_r <= active_s;
      end
    end

    assign clk_o[c]           = clk_r;
    assign rise_o[c]          = rise_r;
    assign fall_o[c]          = fall_r;
    assign drift_applied_o[c] = drift_r;
    assign active_o[c]        = active_r;
  end

endmodule

// File: doc/multi_test_clk.md
Name: multi_test_clk

Overview:
- Parametrised, multi-channel successor to the single-channel test clock generator. Produces CHANNELS independent synthetic IO clocks for clock-recovery benches and loopback self-test.
- Each channel has its own high/low rates, starting polarity, phase offset and programmable drift.
- Rates are counted in clk_en-qualified system cycles, in the same units as the recovery rate counters.
- Outputs feed recovery_pins_s-style inputs directly. Per-channel edge pulses give scoreboard reference events.

Parameters:
- CHANNELS, 2, number of independent clock channels (>=1).
- RATE_WIDTH, 16, width of rate, offset and shadow-rate fields; matches the recovery rate counter width.
- DRIFT_WIDTH, 8, width of the drift interval field.

Ports:
- clk  in  1  system clock.
- async_rst  in  1  asynchronous active-high reset.
- clk_en  in  1  global cycle qualifier. When low, all state holds.
- init_i  in  1  loads per-channel config into shadows and returns all channels to IDLE.
- generation_en_i  in  CHANNELS  per-channel run/pause.
- starting_polarity_i  in  CHANNELS  level of clk_o after init.
- high_rate_i  in  CHANNELS*RATE_WIDTH  cycles high; channel c uses [c*RATE_WIDTH +: RATE_WIDTH].
- low_rate_i  in  CHANNELS*RATE_WIDTH  cycles low.
- phase_offset_i  in  CHANNELS*RATE_WIDTH  extra cycles the initial level is held before the first segment.
- drift_en_i  in  CHANNELS  enables rate drift.
- drift_polarity_i  in  CHANNELS  0 = rates grow (+1), 1 = rates shrink (-1).
- drift_interval_i  in  CHANNELS*DRIFT_WIDTH  rising edges between drift steps; 0 disables drift.
- clk_o  out  CHANNELS  generated clocks (registered).
- rise_o  out  CHANNELS  1-cycle pulse in the same cycle clk_o goes 0->1.
- fall_o  out  CHANNELS  1-cycle pulse in the same cycle clk_o goes 1->0.
- drift_applied_o  out  CHANNELS  1-cycle pulse when the shadow rates change.
- active_o  out  CHANNELS  high when the channel is in OFFSET, HIGH or LOW.

Behaviour:
- Reset: clk_o=0, rise_o=0, fall_o=0, drift_applied_o=0, active_o=0. State IDLE. Counters and shadows are 0.
- Rate 0 in a shadow is treated as 1. All outputs are registered.
- Shadows: rates, offset, polarity, drift interval and drift polarity are captured only on init_i & clk_en. Input changes without init_i are ignored.
- Per-channel FSM, advancing only when clk_en=1:
  - IDLE: clk_o holds its level. When generation_en_i[c]=1: go to OFFSET if offset>0 (count=offset-1). Otherwise go to HIGH or LOW matching the current clk_o level, with count=rate-1.
  - OFFSET: counts down; at 0, enters the segment matching the current level with count=rate-1.
  - HIGH: counts down; at 0, clk_o<=0, fall_o pulses, go to LOW with count=low_rate-1.
  - LOW: counts down; at 0, clk_o<=1, rise_o pulses, go to HIGH with count=high_rate-1.
  - Net result: each level lasts exactly its rate in clk_en cycles. Period = high+low.
- generation_en_i[c]=0 in any non-IDLE state pauses the channel: state, count and level hold, and active_o stays high. Re-assertion resumes with no lost or extra cycles.
- clk_en=0: nothing advances and the pulse outputs are 0.
- init_i priority: init_i overrides everything in the same cycle. All channels go to IDLE, clk_o<=starting polarity, and rise/fall/drift pulses are suppressed even if the level changes. The drift edge counter clears.
- Drift:
  - Each rise_o with drift enabled and interval>0 increments the edge counter.
  - When the counter reaches the interval, it clears, both shadow rates step ±1, and drift_applied_o pulses.
  - Shadow rates saturate in [1, 2^RATE_WIDTH-1]. A saturated step still pulses drift_applied_o.
  - The new rate applies to the next loaded segment, never to the running one.
- A drift step coinciding with a segment load: the load uses the pre-step shadow.
- Channels are fully independent; identical config and timing gives cycle-identical outputs.
- Async reset mid-operation: immediate return to reset values. Resumption requires init_i.

Test Plan:
- CHANNELS=2, both rates=4, polarities 0/1, offset 0, init at cycle 7, enable at 12 -> complementary clocks, period 8. rise_o[0] coincides with fall_o[1]. First ch0 rise occurs 4 cycles after enable.
- high=3, low=5, offset=2, pol 0 -> low held 2+5=7 cycles, then a 3/5 pattern. rise_o and fall_o each pulse exactly once per period.
- Toggle clk_en every other cycle with rates 4/4 -> output period is 16 system cycles. No pulses in clk_en=0 cycles.
- Drop generation_en_i for 10 cycles mid-HIGH (after 2 of 4 cycles) -> clk_o stays high 10 extra cycles, then exactly 2 more high cycles.
- drift_en=1, polarity 1, interval 2, rates 3/3 -> after 2 rises, rates become 2/2 with a drift_applied_o pulse. They reach 1/1 and stay there, still pulsing every 2 rises.
- init_i asserted mid-LOW with starting polarity 1 -> clk_o=1 next cycle, no rise_o, active_o=0. The new shadow rates are used after enable.
